// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state, access-size decoding and store lane helpers
// for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    // Unlisted funct3 codes collapse to a full word access.
    function automatic size_t size_of(input logic [2:0] mode);
        size_t s;
        unique case (1'b1)
            (mode == MODE_B), (mode == MODE_BU): s = SZ_B;
            (mode == MODE_H), (mode == MODE_HU): s = SZ_H;
            default: s = SZ_W;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_rep(
        input logic [2:0]  mode,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (size_of(mode))
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] strobe(
        input logic [2:0] mode,
        input logic [1:0] off
    );
        logic [3:0] s;
        unique case (size_of(mode))
            SZ_B:    s = 4'b0001 << off;
            SZ_H:    s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dcache_store.sv
// dcache_store: tag, valid and data arrays with a combinational read
// port, a byte-enabled word write, a line-fill port and async valid clear.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int IW         = $clog2(SETS),
    parameter int WW         = $clog2(LINE_WORDS),
    parameter int TW         = WIDTH - 2 - IW - WW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    index,
    input  logic [WW-1:0]    word,
    output logic [TW-1:0]    rd_tag,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fill_en,
    input  logic             fill_last,
    input  logic [WW-1:0]    fill_word,
    input  logic [TW-1:0]    fill_tag,
    input  logic [WIDTH-1:0] fill_data
);

    logic [TW-1:0]    tags [SETS];
    logic [WIDTH-1:0] data [SETS][LINE_WORDS];
    logic [SETS-1:0]  valid;

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_data  = data[index][word];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (fill_en && fill_last) begin
            valid[index] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data[index][fill_word] <= fill_data;
            if (fill_last) begin
                tags[index] <= fill_tag;
            end
        end else if (wr_en) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (wr_be[b]) begin
                    data[index][word][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate cache
// between the core load/store path and a handshaked word memory.
module data_cache
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       modeBU,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int TW = WIDTH - 2 - IW - WW;
    localparam logic [WW-1:0] LAST = WW'(LINE_WORDS - 1);

    state_t           state;
    logic [WW-1:0]    cnt;
    logic [WW-1:0]    cnt_nx;
    logic             wdone;

    logic [1:0]       off;
    logic [WW-1:0]    word;
    logic [IW-1:0]    index;
    logic [TW-1:0]    tag;

    logic [TW-1:0]    tag_q;
    logic             tag_v;
    logic             hit;
    logic [WIDTH-1:0] line_word;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] ext;

    logic             fill_en;
    logic             wr_en;

    assign off    = addr[1:0];
    assign word   = addr[2 +: WW];
    assign index  = addr[2+WW +: IW];
    assign tag    = addr[WIDTH-1 -: TW];
    assign hit    = tag_v && (tag_q == tag);
    assign cnt_nx = cnt + WW'(1);

    assign fill_en = (state == REFILL) && mem_ack;
    assign wr_en   = (state == WRITE) && mem_ack && hit;

    dcache_store #(
        .WIDTH      (WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .word      (word),
        .rd_tag    (tag_q),
        .rd_valid  (tag_v),
        .rd_data   (line_word),
        .wr_en     (wr_en),
        .wr_be     (mem_wstrb),
        .wr_data   (mem_wdata),
        .fill_en   (fill_en),
        .fill_last (cnt == LAST),
        .fill_word (cnt),
        .fill_tag  (tag),
        .fill_data (mem_rdata)
    );

    // Misaligned halves/words are force-aligned by the shift amount.
    always_comb begin
        unique case (size_of(modeBU))
            SZ_B:    sh = line_word >> {off, 3'b000};
            SZ_H:    sh = line_word >> {off[1], 4'b0000};
            default: sh = line_word;
        endcase
    end

    always_comb begin
        unique case (1'b1)
            (modeBU == MODE_B):  ext = {{(WIDTH-8){sh[7]}}, sh[7:0]};
            (modeBU == MODE_BU): ext = {{(WIDTH-8){1'b0}}, sh[7:0]};
            (modeBU == MODE_H):  ext = {{(WIDTH-16){sh[15]}}, sh[15:0]};
            (modeBU == MODE_HU): ext = {{(WIDTH-16){1'b0}}, sh[15:0]};
            default:             ext = line_word;
        endcase
    end

    assign rdata = (state == IDLE && req && !we && hit) ? ext : '0;

    // wdone releases the held store for one cycle after its ack,
    // so the core can advance instead of re-issuing the write.
    always_comb begin
        stall = (state != IDLE) || (req && (we ? !wdone : !hit));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wdone     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            wdone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && we && !wdone) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                        mem_wdata <= lane_rep(modeBU, wdata);
                        mem_wstrb <= strobe(modeBU, off);
                    end else if (req && !we && !hit) begin
                        state    <= REFILL;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr[WIDTH-1:2+WW], {WW{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt      <= cnt_nx;
                        mem_addr <= {addr[WIDTH-1:2+WW], cnt_nx, 2'b00};
                        if (cnt == LAST) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        wdone     <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed vector table, reset-mid-refill sequence and
// randomized loads/stores against a byte-level memory and cache-tag model.
module tb_data_cache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  modeBU = 3'b010;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .modeBU(modeBU),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mtag [int];

    int nrd, nwr, busy;
    logic [31:0] rd_log [$];
    int lat_max = 0;
    bit spurious = 0;

    logic [31:0] exp_wd_g, exp_wa_g;
    logic [3:0]  exp_sb_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h8040_2010;
    endfunction

    function automatic logic [31:0] main_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic int nbytes(input logic [2:0] m);
        if (m == 3'b000 || m == 3'b100) return 1;
        if (m == 3'b001 || m == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] m, input logic [31:0] a);
        int n, base;
        n = nbytes(m);
        base = int'(a[1:0]) & ~(n - 1);
        return 4'(((1 << n) - 1) << base);
    endfunction

    function automatic logic [31:0] exp_lane(input logic [2:0] m, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(m);
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = d[(b % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] m,
                                             input logic [31:0] a);
        int n, base;
        logic [31:0] v;
        n = nbytes(m);
        if (n == 4) return w;
        base = int'(a[1:0]) & ~(n - 1);
        v = (w >> (base * 8)) & ((32'd1 << (n * 8)) - 1);
        if ((m == 3'b000 || m == 3'b001) && v[n*8-1]) v = v | ~((32'd1 << (n * 8)) - 1);
        return v;
    endfunction

    // Memory responder: acks after a random number of waits, checks the
    // request stays stable until its ack, and applies strobed writes.
    bit          pend = 0;
    int          wcnt = 0;
    int          cur_wait = 0;
    logic [31:0] h_addr, h_wd, r_old;
    logic [3:0]  h_sb;
    logic        h_we;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst) begin
            pend = 0;
            wcnt = 0;
        end else if (mem_req) begin
            busy++;
            if (pend) begin
                chk("hold_addr", mem_addr, h_addr);
                chk("hold_we", 32'(mem_we), 32'(h_we));
                chk("hold_wdata", mem_wdata, h_wd);
                chk("hold_wstrb", 32'(mem_wstrb), 32'(h_sb));
            end
            if (wcnt >= cur_wait) begin
                mem_ack = 1'b1;
                pend = 0;
                wcnt = 0;
                cur_wait = (lat_max == 0) ? 0 : $urandom_range(0, lat_max);
                if (mem_we) begin
                    nwr++;
                    chk("wr_addr", mem_addr, exp_wa_g);
                    chk("wr_wstrb", 32'(mem_wstrb), 32'(exp_sb_g));
                    chk("wr_wdata", mem_wdata, exp_wd_g);
                    r_old = main_rd(mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) r_old[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    mem[mem_addr] = r_old;
                end else begin
                    nrd++;
                    chk("rd_wstrb", 32'(mem_wstrb), 32'h0);
                    rd_log.push_back(mem_addr);
                    mem_rdata = main_rd(mem_addr);
                end
            end else begin
                wcnt++;
                pend = 1;
                h_addr = mem_addr;
                h_we = mem_we;
                h_wd = mem_wdata;
                h_sb = mem_wstrb;
            end
        end else begin
            if (pend) begin
                total++;
                bad++;
                $display("FAIL req_dropped: mem_req 0 before ack");
            end
            pend = 0;
            if (spurious) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    task automatic do_op(input logic w, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output int st);
        int g;
        @(negedge clk);
        req = 1'b1; we = w; modeBU = m; addr = a; wdata = d;
        nrd = 0; nwr = 0; busy = 0;
        rd_log.delete();
        st = 0; g = 0;
        #1;
        while (stall && g < 200) begin
            st++; g++;
            @(negedge clk);
            #1;
        end
        if (g >= 200) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: addr %h still stalled", a);
        end
        rd = rdata;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic run_model(input logic w, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd, output int st);
        logic [31:0] wa, line, er, lanes, old;
        logic [3:0]  sb;
        int idx;
        bit hit;
        wa = {a[31:2], 2'b00};
        line = {a[31:4], 4'b0000};
        idx = int'(a[7:4]);
        hit = mtag.exists(idx) && mtag[idx] == line;
        lanes = exp_lane(m, d);
        sb = exp_strb(m, a);
        exp_wd_g = lanes; exp_sb_g = sb; exp_wa_g = wa;
        er = w ? 32'h0 : exp_load(ref_rd(wa), m, a);
        do_op(w, m, a, d, rd, st);
        chk("rdata", rd, er);
        if (w) begin
            chk("st_writes", nwr, 1);
            chk("st_reads", nrd, 0);
            chk("st_stall", st, 1 + busy);
            old = ref_rd(wa);
            for (int b = 0; b < 4; b++) if (sb[b]) old[b*8 +: 8] = lanes[b*8 +: 8];
            ref_mem[wa] = old;
        end else if (hit) begin
            chk("hit_reads", nrd, 0);
            chk("hit_stall", st, 0);
        end else begin
            chk("miss_reads", nrd, 4);
            chk("miss_stall", st, 1 + busy);
            for (int i = 0; i < rd_log.size() && i < 4; i++)
                chk("refill_addr", rd_log[i], line + 32'(4 * i));
            mtag[idx] = line;
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        int          es;
        int          erd;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [31:0] rd;
        int st, g;
        logic w;
        logic [2:0] m;
        logic [31:0] a;
        logic [2:0] lmodes [6];
        lmodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
            ref_mem[32'h100 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
        end

        tbl.push_back('{0, MODE_W,  32'h100, 32'h0,        32'h11,       5, 4});
        tbl.push_back('{0, MODE_W,  32'h108, 32'h0,        32'h33,       0, 0});
        tbl.push_back('{1, MODE_W,  32'h104, 32'h0000_80FF, 32'h0,       2, 0});
        tbl.push_back('{0, MODE_B,  32'h104, 32'h0,        32'hFFFF_FFFF, 0, 0});
        tbl.push_back('{0, MODE_BU, 32'h104, 32'h0,        32'h0000_00FF, 0, 0});
        tbl.push_back('{0, MODE_H,  32'h104, 32'h0,        32'hFFFF_80FF, 0, 0});
        tbl.push_back('{0, MODE_HU, 32'h106, 32'h0,        32'h0,         0, 0});
        tbl.push_back('{0, MODE_H,  32'h105, 32'h0,        32'hFFFF_80FF, 0, 0});
        tbl.push_back('{1, MODE_B,  32'h105, 32'hAB,       32'h0,         2, 0});
        tbl.push_back('{0, MODE_W,  32'h104, 32'h0,        32'h0000_ABFF, 0, 0});
        tbl.push_back('{0, MODE_W,  32'h107, 32'h0,        32'h0000_ABFF, 0, 0});
        tbl.push_back('{0, 3'b011,  32'h104, 32'h0,        32'h0000_ABFF, 0, 0});
        tbl.push_back('{1, MODE_W,  32'h500, 32'hDEAD_BEEF, 32'h0,        2, 0});
        tbl.push_back('{0, MODE_W,  32'h500, 32'h0,        32'hDEAD_BEEF, 5, 4});
        tbl.push_back('{0, MODE_W,  32'h104, 32'h0,        32'h0000_ABFF, 5, 4});

        #3;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run_model(tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d, rd, st);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er);
            chk($sformatf("tbl%0d_stall", i), st, tbl[i].es);
            chk($sformatf("tbl%0d_reads", i), nrd, tbl[i].erd);
        end

        @(negedge clk);
        spurious = 1;
        repeat (3) @(negedge clk);
        spurious = 0;
        run_model(0, MODE_W, 32'h10C, 32'h0, rd, st);
        chk("after_spurious", rd, 32'h44);

        @(negedge clk);
        req = 1'b1; we = 1'b0; modeBU = MODE_W; addr = 32'h200;
        nrd = 0;
        rd_log.delete();
        g = 0;
        while (nrd < 2 && g < 50) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        rst = 1'b0;
        req = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_wstrb", 32'(mem_wstrb), 32'h0);
        mtag.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_model(0, MODE_W, 32'h200, 32'h0, rd, st);
        chk("rerefill_reads", nrd, 4);
        run_model(0, MODE_W, 32'h104, 32'h0, rd, st);

        lat_max = 2;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 2) == 0);
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | 32'($urandom_range(0, 15));
            m = w ? 3'($urandom_range(0, 2)) : lmodes[$urandom_range(0, 5)];
            run_model(w, m, a, $urandom, rd, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
